// File: rtl/caf_pkg.sv
// Shared types and width/offset helpers for the CAF sweep sequencer.
// Result beat layout: {bin, lag, mag} with mag in the LSBs.
package caf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_COLLECT,
    ST_REPORT
  } state_t;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int lag_lsb(input int mag_w);
    return mag_w;
  endfunction

  function automatic int bin_lsb(input int mag_w, input int lag_w);
    return mag_w + lag_w;
  endfunction

endpackage

// File: rtl/caf_peak_tracker.sv
// Compare/hold register for the running CAF peak; strict greater-than keeps
// the earliest (bin, lag) on ties.
module caf_peak_tracker
  import caf_pkg::*;
#(
  parameter int BIN_W     = 3,
  parameter int LAG_W     = 4,
  parameter int MAG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [BIN_W-1:0]     bin,
  input  logic [LAG_W-1:0]     lag,
  input  logic [MAG_WIDTH-1:0] mag,
  output logic                 valid,
  output logic [BIN_W-1:0]     peak_bin,
  output logic [LAG_W-1:0]     peak_lag,
  output logic [MAG_WIDTH-1:0] peak_mag
);

  // NOTE: the held peak is reset as well as its valid flag, so the result bus
  // reads zero out of reset instead of power-up garbage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      peak_bin <= '0;
      peak_lag <= '0;
      peak_mag <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (en && (!valid || mag > peak_mag)) begin
      valid    <= 1'b1;
      peak_bin <= bin;
      peak_lag <= lag;
      peak_mag <= mag;
    end
  end

endmodule

// File: rtl/caf_sweep_ctrl.sv
// CAF sweep sequencer: steps the core through every bin, tracks the global
// peak and reports it once. Optional abort input under CAF_SWEEP_ABORT_EN.
module caf_sweep_ctrl
  import caf_pkg::*;
#(
  parameter  int NUM_BINS  = 8,
  parameter  int NUM_LAGS  = 16,
  parameter  int MAG_WIDTH = 32,
  localparam int BIN_W     = clog2(NUM_BINS),
  localparam int LAG_W     = clog2(NUM_LAGS),
  localparam int DATA_W    = BIN_W + LAG_W + MAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
`ifdef CAF_SWEEP_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [BIN_W-1:0]     core_freq_idx,
  output logic                 core_start,
  input  logic [MAG_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [DATA_W-1:0]    m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
  localparam logic [LAG_W-1:0] LAST_LAG = LAG_W'(NUM_LAGS - 1);
  localparam int LAG_LSB = lag_lsb(MAG_WIDTH);
  localparam int BIN_LSB = bin_lsb(MAG_WIDTH, LAG_W);

  state_t               state;
  logic [BIN_W-1:0]     bin;
  logic [LAG_W-1:0]     lag;
  logic                 abort_hit;
  logic                 beat;
  logic                 peak_valid;
  logic [BIN_W-1:0]     peak_bin;
  logic [LAG_W-1:0]     peak_lag;
  logic [MAG_WIDTH-1:0] peak_mag;

`ifdef CAF_SWEEP_ABORT_EN
  assign abort_hit = abort && (state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // tready is only high in COLLECT, so this is the accepted-beat strobe.
  assign beat = s_axis_tready && s_axis_tvalid && !abort_hit;

  caf_peak_tracker #(
    .BIN_W    (BIN_W),
    .LAG_W    (LAG_W),
    .MAG_WIDTH(MAG_WIDTH)
  ) u_peak (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((state == ST_IDLE) && start),
    .en      (beat),
    .bin     (bin),
    .lag     (lag),
    .mag     (s_axis_tdata),
    .valid   (peak_valid),
    .peak_bin(peak_bin),
    .peak_lag(peak_lag),
    .peak_mag(peak_mag)
  );

  // NOTE: every output of always_comb gets a default first so no latch forms.
  always_comb begin
    m_axis_tdata = '0;
    if (peak_valid) begin
      m_axis_tdata[BIN_LSB +: BIN_W]     = peak_bin;
      m_axis_tdata[LAG_LSB +: LAG_W]     = peak_lag;
      m_axis_tdata[0 +: MAG_WIDTH]       = peak_mag;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bin           <= '0;
      lag           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      core_freq_idx <= '0;
      core_start    <= 1'b0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      if (abort_hit) begin
        state         <= ST_IDLE;
        busy          <= 1'b0;
        s_axis_tready <= 1'b0;
        m_axis_tvalid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            state         <= ST_CONFIG;
            bin           <= '0;
            lag           <= '0;
            err           <= 1'b0;
            busy          <= 1'b1;
            core_start    <= 1'b1;
            core_freq_idx <= '0;
          end
          ST_CONFIG: begin
            state         <= ST_COLLECT;
            s_axis_tready <= 1'b1;
          end
          ST_COLLECT: if (beat) begin
            if ((lag == LAST_LAG) != s_axis_tlast) err <= 1'b1;
            if (s_axis_tlast) begin
              lag           <= '0;
              s_axis_tready <= 1'b0;
              if (bin == LAST_BIN) begin
                state         <= ST_REPORT;
                m_axis_tvalid <= 1'b1;
              end else begin
                state         <= ST_CONFIG;
                bin           <= bin + 1'b1;
                core_freq_idx <= bin + 1'b1;
                core_start    <= 1'b1;
              end
            end else if (lag != LAST_LAG) begin
              lag <= lag + 1'b1;
            end
          end
          ST_REPORT: if (m_axis_tready) begin
            state         <= ST_IDLE;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_caf_sweep_ctrl.sv
// Bench for caf_sweep_ctrl: directed and randomized sweeps scored against a
// flat "scan all beats, keep strict max" model of the sweep.
module tb_caf_sweep_ctrl;
  import caf_pkg::*;

  localparam int NB      = 4;
  localparam int NL      = 4;
  localparam int MAG_W   = 32;
  localparam int BIN_W   = clog2(NB);
  localparam int LAG_W   = clog2(NL);
  localparam int DATA_W  = BIN_W + LAG_W + MAG_W;
  localparam int LAG_LSB = lag_lsb(MAG_W);
  localparam int BIN_LSB = bin_lsb(MAG_W, LAG_W);
  localparam int MAXB    = 6;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic busy, done, err, core_start, s_axis_tready, m_axis_tvalid, m_axis_tready;
  logic s_axis_tvalid, s_axis_tlast;
  logic [BIN_W-1:0]  core_freq_idx;
  logic [MAG_W-1:0]  s_axis_tdata;
  logic [DATA_W-1:0] m_axis_tdata;

  always #5 clk = ~clk;

  caf_sweep_ctrl #(.NUM_BINS(NB), .NUM_LAGS(NL), .MAG_WIDTH(MAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
`ifdef CAF_SWEEP_ABORT_EN
    .abort        (abort),
`endif
    .busy         (busy),
    .done         (done),
    .err          (err),
    .core_freq_idx(core_freq_idx),
    .core_start   (core_start),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Sweep description shared by the driver and the model.
  int          lens   [NB];
  logic [31:0] mag_tab[NB][MAXB];

  function automatic logic [63:0] pack(input int b, input int l, input logic [31:0] m);
    return (64'(b) << BIN_LSB) | (64'(l) << LAG_LSB) | 64'(m);
  endfunction

  task automatic model(output logic [63:0] pk, output bit e);
    bit have = 0;
    logic [31:0] best = '0;
    int bb = 0, bl = 0;
    e = 0;
    for (int b = 0; b < NB; b++) begin
      if (lens[b] != NL) e = 1;
      for (int i = 0; i < lens[b]; i++) begin
        if (!have || mag_tab[b][i] > best) begin
          have = 1;
          best = mag_tab[b][i];
          bb   = b;
          bl   = (i < NL) ? i : NL - 1;
        end
      end
    end
    pk = pack(bb, bl, best);
  endtask

  task automatic fill_ramp();
    for (int b = 0; b < NB; b++) begin
      lens[b] = NL;
      for (int i = 0; i < MAXB; i++) mag_tab[b][i] = 32'(b * 10 + i);
    end
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int b = 0; b < NB; b++) begin
      lens[b] = NL;
      for (int i = 0; i < MAXB; i++) mag_tab[b][i] = v;
    end
  endtask

  // Monitor state
  logic [BIN_W-1:0]  cs_q[$];
  logic [DATA_W-1:0] res_q[$];
  int                done_cnt = 0;
  bit                prev_rst = 1'b1, prev_hs = 1'b0, prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;

  always @(negedge clk) begin
    if (!prev_rst) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_core_start", core_start, 0);
      check("rst_s_tready", s_axis_tready, 0);
      check("rst_m_tvalid", m_axis_tvalid, 0);
      check("rst_freq_idx", core_freq_idx, 0);
      check("rst_m_tdata", m_axis_tdata, 0);
    end else begin
      if (core_start) begin
        cs_q.push_back(core_freq_idx);
        check("busy_with_core_start", busy, 1);
      end
      if (prev_hs) begin
        check("done_after_hs", done, 1);
        check("busy_after_hs", busy, 0);
        check("mvalid_after_hs", m_axis_tvalid, 0);
      end else if (done === 1'b1) begin
        check("done_spurious", done, 0);
      end
      if (done === 1'b1) done_cnt++;
      if (prev_stall) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_data", m_axis_tdata, prev_data);
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) res_q.push_back(m_axis_tdata);
    end
    prev_hs    = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b1) && rst_n;
    prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0) && rst_n;
    prev_data  = m_axis_tdata;
    prev_rst   = rst_n;
  end

  logic [63:0] last_res;
  logic        last_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one sweep from IDLE; cut >= 0 stops after that many beats.
  task automatic run_sweep(input bit gaps, input int stall, input int cut, input bit start_noise);
    int beats = 0;
    bit ok;
    cs_q.delete();
    res_q.delete();
    done_cnt = 0;
    last_res = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_core_start", core_start, 1);
    check("start_busy", busy, 1);
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < lens[b]; i++) begin
        if (cut >= 0 && beats == cut) return;
        if (gaps) begin
          int g;
          g = $urandom_range(0, 2);
          repeat (g) tick();
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = mag_tab[b][i];
        s_axis_tlast  = (i == lens[b] - 1);
        if (start_noise && b == 1) start = 1'b1;
        ok = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
          ok = s_axis_tready;
          tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        start         = 1'b0;
        if (!ok) begin
          check("beat_timeout", 0, 1);
          return;
        end
        beats++;
        if (i == lens[b] - 1) begin
          if (b < NB - 1) check("turnaround_core_start", core_start, 1);
          else            check("report_valid_m1", m_axis_tvalid, 1);
        end
      end
    end
    repeat (stall) tick();
    m_axis_tready = 1'b1;
    ok = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      ok = m_axis_tvalid;
      tick();
    end
    m_axis_tready = 1'b0;
    if (!ok) begin
      check("report_timeout", 0, 1);
      return;
    end
    repeat (3) tick();
    check("busy_idle", busy, 0);
    check("done_count", done_cnt, 1);
    check("result_count", res_q.size(), 1);
    check("core_start_count", cs_q.size(), NB);
    for (int k = 0; k < NB && k < cs_q.size(); k++) check("core_freq_idx_seq", cs_q[k], k);
    if (res_q.size() > 0) last_res = 64'(res_q[0]);
    last_err = err;
  endtask

  logic [63:0] exp_pk, gapfree;
  bit          exp_e;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Ramp: peak 33 at (3,3).
    fill_ramp();
    model(exp_pk, exp_e);
    check("model_pin_ramp", exp_pk, pack(3, 3, 33));
    run_sweep(0, 0, -1, 0);
    check("ramp_res", last_res, pack(3, 3, 33));
    check("ramp_err", last_err, 0);

    // Tie: earliest of two equal peaks wins.
    fill_const(5);
    mag_tab[1][2] = 50;
    mag_tab[3][0] = 50;
    model(exp_pk, exp_e);
    check("model_pin_tie", exp_pk, pack(1, 2, 50));
    run_sweep(0, 0, -1, 0);
    check("tie_res", last_res, pack(1, 2, 50));

    // All zero: first beat loads the invalid peak.
    fill_const(0);
    run_sweep(0, 0, -1, 0);
    check("zero_res", last_res, pack(0, 0, 0));

    // Short bin: tlast on 3rd beat of bin 2.
    fill_ramp();
    lens[2] = 3;
    run_sweep(0, 0, -1, 0);
    check("short_res", last_res, pack(3, 3, 33));
    check("short_err", last_err, 1);

    // Long bin: 5 beats in bin 1, the fifth is the peak at saturated lag.
    fill_ramp();
    lens[1] = 5;
    mag_tab[1][4] = 99;
    model(exp_pk, exp_e);
    check("model_pin_long", exp_pk, pack(1, 3, 99));
    run_sweep(0, 0, -1, 0);
    check("long_res", last_res, pack(1, 3, 99));
    check("long_err", last_err, 1);

    // Random data: gap-free vs gapped with a 7-cycle result stall.
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < NB; b++) begin
        lens[b] = NL;
        for (int i = 0; i < MAXB; i++) mag_tab[b][i] = 32'($urandom_range(0, 15));
      end
      model(exp_pk, exp_e);
      run_sweep(0, 0, -1, 0);
      gapfree = last_res;
      check("rand_res", last_res, exp_pk);
      check("rand_err", last_err, exp_e);
      run_sweep(1, 7, -1, 1);
      check("gap_res", last_res, exp_pk);
      check("gap_same", last_res, gapfree);
    end

    // Reset mid bin 2 with a stale huge peak, then a fresh ramp sweep.
    fill_ramp();
    mag_tab[0][0] = 1000;
    run_sweep(0, 0, 2 * NL + 2, 0);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    fill_ramp();
    run_sweep(0, 0, -1, 0);
    check("post_reset_res", last_res, pack(3, 3, 33));
    check("post_reset_err", last_err, 0);

`ifdef CAF_SWEEP_ABORT_EN
    fill_ramp();
    run_sweep(0, 0, 5, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_s_tready", s_axis_tready, 0);
    check("abort_m_tvalid", m_axis_tvalid, 0);
    repeat (5) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_no_result", res_q.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
